wr_resp_4ton_xbar: RTL and testbench
====================================

Name: wr_resp_4ton_xbar

Overview:
- Return path for write requests that the per-direction write crossbar fans out to the 4 hash slices.
- Collects write completions from the 4 hash-slice banks of one direction (W/E/S/N) and routes each completion back to the requester port that issued the write.
- One instance per direction; per-output round-robin arbitration across banks, with a registered output stage and full valid/ready backpressure.

Parameters:
- OUT_NUM, 4, number of requester ports in this direction (WW/EW/SW/NW_REQ_NUM), range 1..8
- DST_W, 3, width of the destination requester index; must satisfy 2**DST_W >= OUT_NUM
- TXNID_W, TXNID_WIDTH, transaction id width
- SB_W, SIDEBAND_WIDTH, sideband width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- bank_resp_vld  in  4  completion valid per hash slice
- bank_resp_rdy  out  4  completion accepted per hash slice
- bank_resp_txnid  in  TXNID_W x4  txnid echoed from the write request
- bank_resp_sideband  in  SB_W x4  sideband echoed from the write request
- bank_resp_dst  in  DST_W x4  requester port index of the original write
- resp_vld  out  OUT_NUM  completion valid to requester
- resp_rdy  in  OUT_NUM  requester accepts completion
- resp_txnid  out  TXNID_W xOUT_NUM  returned txnid
- resp_sideband  out  SB_W xOUT_NUM  returned sideband
- err_dst  out  1  sticky flag: a completion arrived with dst >= OUT_NUM

Behaviour:
- Reset values: resp_vld=0, resp_txnid=0, resp_sideband=0, err_dst=0, all RR pointers=0. bank_resp_rdy is combinational and evaluates to 0 while no requests are pending.
- Request matrix: req[j][i] = bank_resp_vld[i] & (bank_resp_dst[i]==j).
- Per-output slot j (one output register):
  - slot_free[j] = !resp_vld[j] | resp_rdy[j]. Back-to-back transfers at full rate are supported.
  - If slot_free[j] and any req[j][*] is set, a round-robin grant selects bank i: search starts at ptr[j], wrapping 3->0.
  - bank_resp_rdy[i]=1 in the same cycle. On the next edge the register loads txnid/sideband from bank i and resp_vld[j]=1.
  - ptr[j] <= (i+1) mod 4, updated only on a grant.
- If slot_free[j]=0, no bank targeting j is granted; those banks see rdy=0 and must hold vld and payload stable.
- If the slot drains and no new grant occurs in the same cycle, resp_vld[j] <= 0.
- Latency: bank handshake to resp_vld is exactly 1 cycle. Throughput is 1 completion per cycle per output.
- Independent outputs: banks targeting different j are granted in the same cycle, so up to min(4,OUT_NUM) grants per cycle.
- Each bank targets exactly one j per cycle, so bank_resp_rdy[i] = OR over j of gnt[j][i].
- Illegal destination (bank_resp_dst[i] >= OUT_NUM):
  - bank_resp_rdy[i]=1 immediately and the completion is dropped, so the bank is never blocked.
  - err_dst is set and stays set until reset.
- rdy must not depend on the requester's own resp_rdy except through slot_free; there are no combinational paths from vld to vld.
- Reset asserted mid-operation: all registers clear asynchronously and held completions are lost. This is acceptable because the banks are reset on the same rst_n.
- Output protocol: once resp_vld[j]=1, payload is stable until resp_rdy[j]=1.

Decomposition:
- vector_cache_pkg gains:
  - wr_resp_pld_t {txnid, sideband}
  - WR_RESP_BANK_NUM=4
  - WR_RESP_DST_W
- Sub-module rr_arb4: 4 requests, an enable input, a one-hot grant, and an internal pointer that advances only on a grant. Instantiated OUT_NUM times.
- The top level holds the request matrix, the output registers, the rdy OR-reduction and err_dst.

Test Plan:
- Single completion: bank2 vld, dst=1, txnid=0x15, resp_rdy=all 1. Expect bank_resp_rdy=4'b0100 in cycle 0; resp_vld=4'b0010 and resp_txnid[1]=0x15 in cycle 1; resp_vld=0 in cycle 2.
- Round-robin fairness: all 4 banks hold vld continuously with dst=0, txnids 0xA0..0xA3, resp_rdy[0]=1. Expect outputs in order A0,A1,A2,A3,A0, one per cycle, with each bank's rdy pulsing once every 4 cycles.
- Parallel outputs: banks 0..3 with dst=3,2,1,0. Expect bank_resp_rdy=4'b1111 in one cycle; next cycle all 4 resp_vld=1 with matching txnids.
- Backpressure: dst=0 from bank1 while resp_rdy[0]=0 for 5 cycles after the first completion loads. Expect resp payload stable, bank1 rdy=0 for those cycles; after rdy rises, the second completion appears the next cycle with no gap.
- Illegal destination: OUT_NUM=3, bank0 dst=3. Expect bank_resp_rdy[0]=1, no resp_vld, and err_dst=1 sticky until rst_n is pulsed low.
- Mid-operation reset: with resp_vld[1]=1 held, assert rst_n low asynchronously between edges. Expect resp_vld=0 and err_dst=0 immediately; after release, the next grant starts from bank 0.

Source files
------------

// File: rtl/wr_resp_4ton_xbar_pkg.sv
// Shared definitions for the write-response return crossbar.
// Contents:
//   TXNID_WIDTH / SIDEBAND_WIDTH : default payload field widths
//   WR_RESP_BANK_NUM             : number of hash-slice banks feeding one direction
//   WR_RESP_DST_W                : default width of the requester index
//   wr_resp_pld_t                : one completion payload {txnid, sideband}
//   wr_resp_rr_idx()             : 2-bit wrap-around index helper for the RR search
package wr_resp_4ton_xbar_pkg;

  localparam int TXNID_WIDTH      = 8;
  localparam int SIDEBAND_WIDTH   = 4;
  localparam int WR_RESP_BANK_NUM = 4;
  localparam int WR_RESP_DST_W    = 3;

  typedef struct packed {
    logic [TXNID_WIDTH-1:0]    txnid;
    logic [SIDEBAND_WIDTH-1:0] sideband;
  } wr_resp_pld_t;

  // Bank index reached by stepping 'off' positions from 'base', wrapping 3->0.
  function automatic logic [1:0] wr_resp_rr_idx(input logic [1:0] base, input logic [1:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/wr_resp_4ton_xbar_if.sv
// Bus bundle between the 4 hash-slice banks of one direction, the return
// crossbar and the OUT_NUM requester ports.
//   bank_resp_*  : completions coming from the banks (vld/rdy + txnid, sideband, dst)
//   resp_*       : completions delivered to the requesters (vld/rdy + txnid, sideband)
// Modports:
//   master : the bank + requester environment (drives bank completions and resp_rdy)
//   slave  : the crossbar (drives bank_resp_rdy and the resp_* outputs)
//
// Handshake: a transfer happens on a rising edge where vld and rdy are both 1.
// A source holding vld=1 keeps vld and its payload stable until it sees rdy=1;
// vld never depends combinationally on rdy.
interface wr_resp_4ton_xbar_if
  import wr_resp_4ton_xbar_pkg::*;
#(
  parameter int OUT_NUM = 4,
  parameter int DST_W   = WR_RESP_DST_W,
  parameter int TXNID_W = TXNID_WIDTH,
  parameter int SB_W    = SIDEBAND_WIDTH
) ();

  logic [WR_RESP_BANK_NUM-1:0]              bank_resp_vld;
  logic [WR_RESP_BANK_NUM-1:0]              bank_resp_rdy;
  logic [WR_RESP_BANK_NUM-1:0][TXNID_W-1:0] bank_resp_txnid;
  logic [WR_RESP_BANK_NUM-1:0][SB_W-1:0]    bank_resp_sideband;
  logic [WR_RESP_BANK_NUM-1:0][DST_W-1:0]   bank_resp_dst;

  logic [OUT_NUM-1:0]                       resp_vld;
  logic [OUT_NUM-1:0]                       resp_rdy;
  logic [OUT_NUM-1:0][TXNID_W-1:0]          resp_txnid;
  logic [OUT_NUM-1:0][SB_W-1:0]             resp_sideband;

  modport master (
    output bank_resp_vld, bank_resp_txnid, bank_resp_sideband, bank_resp_dst, resp_rdy,
    input  bank_resp_rdy, resp_vld, resp_txnid, resp_sideband
  );

  modport slave (
    input  bank_resp_vld, bank_resp_txnid, bank_resp_sideband, bank_resp_dst, resp_rdy,
    output bank_resp_rdy, resp_vld, resp_txnid, resp_sideband
  );

endinterface

// File: rtl/wr_resp_4ton_xbar_rr_arb4.sv
// Four-way round-robin arbiter used once per requester output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : grant allowed this cycle (output slot can take a completion)
//   req[3:0]   : banks requesting this output
//   gnt[3:0]   : one-hot grant, all zero when en=0 or no request
// The search starts at the stored pointer and wraps 3->0; the pointer moves
// to the bank after the winner only when a grant is issued.
module wr_resp_4ton_xbar_rr_arb4
  import wr_resp_4ton_xbar_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    idx   = '0;
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        idx = wr_resp_rr_idx(ptr_q, 2'(k));
        // First requester found in priority order wins; later ones are masked.
        if (req[idx] && (gnt == 4'b0000)) begin
          gnt[idx] = 1'b1;
          ptr_d    = idx + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wr_resp_4ton_xbar.sv
// Write-completion return crossbar for one direction.
// Routes completions from the 4 hash-slice banks to the requester port named
// by each completion's dst field, with one round-robin arbiter and one output
// register per requester.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bank completions in, requester completions out (slave side)
//   err_dst    : sticky, set when a completion names a port >= OUT_NUM
// Completions with an out-of-range dst are accepted immediately and dropped
// so a misbehaving bank never stalls.
module wr_resp_4ton_xbar
  import wr_resp_4ton_xbar_pkg::*;
#(
  parameter int OUT_NUM = 4,
  parameter int DST_W   = WR_RESP_DST_W,
  parameter int TXNID_W = TXNID_WIDTH,
  parameter int SB_W    = SIDEBAND_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  wr_resp_4ton_xbar_if.slave bus,
  output logic               err_dst
);

  localparam int NB = WR_RESP_BANK_NUM;

  typedef struct packed {
    logic [TXNID_W-1:0] txnid;
    logic [SB_W-1:0]    sideband;
  } pld_t;

  logic [OUT_NUM-1:0][NB-1:0] req;
  logic [OUT_NUM-1:0][NB-1:0] gnt;
  logic [NB-1:0]              illegal;
  logic [NB-1:0]              bank_rdy;
  logic [OUT_NUM-1:0]         slot_free;
  logic [OUT_NUM-1:0]         resp_vld_q, resp_vld_d;
  pld_t [OUT_NUM-1:0]         pld_q, pld_d;
  logic                       err_q, err_d;

  // Request matrix: each valid bank asks exactly one output, or none if its
  // dst is out of range.
  always_comb begin
    req     = '0;
    illegal = '0;
    for (int i = 0; i < NB; i++) begin
      illegal[i] = bus.bank_resp_vld[i] && (int'(bus.bank_resp_dst[i]) >= OUT_NUM);
      for (int j = 0; j < OUT_NUM; j++) begin
        req[j][i] = bus.bank_resp_vld[i] && (bus.bank_resp_dst[i] == DST_W'(j));
      end
    end
  end

  // A slot can load when empty or when its current entry leaves this cycle,
  // which gives back-to-back transfers at full rate.
  assign slot_free = ~resp_vld_q | bus.resp_rdy;

  for (genvar j = 0; j < OUT_NUM; j++) begin : g_out
    wr_resp_4ton_xbar_rr_arb4 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (slot_free[j]),
      .req   (req[j]),
      .gnt   (gnt[j])
    );

    assign bus.resp_txnid[j]    = pld_q[j].txnid;
    assign bus.resp_sideband[j] = pld_q[j].sideband;
  end

  always_comb begin
    resp_vld_d = resp_vld_q;
    pld_d      = pld_q;
    bank_rdy   = illegal;
    err_d      = err_q | (|illegal);
    for (int j = 0; j < OUT_NUM; j++) begin
      if (|gnt[j]) begin
        resp_vld_d[j] = 1'b1;
        for (int i = 0; i < NB; i++) begin
          if (gnt[j][i]) begin
            pld_d[j].txnid    = bus.bank_resp_txnid[i];
            pld_d[j].sideband = bus.bank_resp_sideband[i];
          end
        end
      end else if (slot_free[j]) begin
        resp_vld_d[j] = 1'b0;
      end
      // A bank requests a single output, so ORing the grant rows cannot
      // acknowledge one completion twice.
      bank_rdy = bank_rdy | gnt[j];
    end
  end

  assign bus.bank_resp_rdy = bank_rdy;
  assign bus.resp_vld      = resp_vld_q;
  assign err_dst           = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vld_q <= '0;
      pld_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      resp_vld_q <= resp_vld_d;
      pld_q      <= pld_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_wr_resp_4ton_xbar.sv
module tb_wr_resp_4ton_xbar;
  import wr_resp_4ton_xbar_pkg::*;

  localparam int OUT_NUM = 4;
  localparam int DST_W   = WR_RESP_DST_W;
  localparam int TXNID_W = TXNID_WIDTH;
  localparam int SB_W    = SIDEBAND_WIDTH;
  localparam int NB      = WR_RESP_BANK_NUM;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic err_dst, err_dst3;

  wr_resp_4ton_xbar_if #(.OUT_NUM(OUT_NUM), .DST_W(DST_W), .TXNID_W(TXNID_W), .SB_W(SB_W)) bus ();
  wr_resp_4ton_xbar_if #(.OUT_NUM(3), .DST_W(DST_W), .TXNID_W(TXNID_W), .SB_W(SB_W)) bus3 ();

  wr_resp_4ton_xbar #(.OUT_NUM(OUT_NUM), .DST_W(DST_W), .TXNID_W(TXNID_W), .SB_W(SB_W)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_dst (err_dst)
  );

  wr_resp_4ton_xbar #(.OUT_NUM(3), .DST_W(DST_W), .TXNID_W(TXNID_W), .SB_W(SB_W)) u_dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus3),
    .err_dst (err_dst3)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus state ----------------
  logic               b_vld [NB];
  int                 b_dst [NB];
  logic [TXNID_W-1:0] b_txn [NB];
  logic [SB_W-1:0]    b_sb  [NB];
  logic [OUT_NUM-1:0] r_rdy;
  logic [NB-1:0]      last_rdy;

  // ---------------- reference model / scoreboard ----------------
  // exp_q[j] holds the completion that requester j should currently see.
  wr_resp_pld_t exp_q [OUT_NUM][$];
  int           m_ptr [OUT_NUM];
  logic         m_err;

  task automatic drive();
    for (int i = 0; i < NB; i++) begin
      bus.bank_resp_vld[i]      = b_vld[i];
      bus.bank_resp_dst[i]      = DST_W'(b_dst[i]);
      bus.bank_resp_txnid[i]    = b_txn[i];
      bus.bank_resp_sideband[i] = b_sb[i];
    end
    bus.resp_rdy = r_rdy;
  endtask

  task automatic drive3_idle();
    bus3.bank_resp_vld      = '0;
    bus3.bank_resp_dst      = '0;
    bus3.bank_resp_txnid    = '0;
    bus3.bank_resp_sideband = '0;
    bus3.resp_rdy           = '1;
  endtask

  // Applies the routing rules to the inputs presented this cycle: returns which
  // banks must be acknowledged and advances the expected output contents.
  task automatic model_step(output logic [NB-1:0] exp_rdy);
    wr_resp_pld_t p;
    int           bank;
    exp_rdy = '0;
    for (int i = 0; i < NB; i++) begin
      if (b_vld[i] && b_dst[i] >= OUT_NUM) begin
        exp_rdy[i] = 1'b1;
        m_err      = 1'b1;
      end
    end
    for (int j = 0; j < OUT_NUM; j++) begin
      if (exp_q[j].size() != 0 && r_rdy[j]) void'(exp_q[j].pop_front());
      if (exp_q[j].size() == 0) begin
        for (int k = 0; k < NB; k++) begin
          bank = (m_ptr[j] + k) % NB;
          if (b_vld[bank] && b_dst[bank] == j) begin
            exp_rdy[bank] = 1'b1;
            p.txnid       = b_txn[bank];
            p.sideband    = b_sb[bank];
            exp_q[j].push_back(p);
            m_ptr[j]      = (bank + 1) % NB;
            break;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int j = 0; j < OUT_NUM; j++) begin
      check($sformatf("resp_vld[%0d]", j), 32'(bus.resp_vld[j]), 32'(exp_q[j].size() != 0));
      if (exp_q[j].size() != 0) begin
        check($sformatf("resp_txnid[%0d]", j), 32'(bus.resp_txnid[j]), 32'(exp_q[j][0].txnid));
        check($sformatf("resp_sideband[%0d]", j), 32'(bus.resp_sideband[j]), 32'(exp_q[j][0].sideband));
      end
    end
    check("err_dst", 32'(err_dst), 32'(m_err));
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle();
    logic [NB-1:0] exp_rdy;
    check_outputs();
    drive();
    #1;
    model_step(exp_rdy);
    last_rdy = bus.bank_resp_rdy;
    check("bank_resp_rdy", 32'(last_rdy), 32'(exp_rdy));
    @(posedge clk);
    for (int i = 0; i < NB; i++) if (b_vld[i] && last_rdy[i]) b_vld[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NB; i++) begin
      b_vld[i] = 1'b0; b_dst[i] = 0; b_txn[i] = '0; b_sb[i] = '0;
    end
    r_rdy = '1;
    drive();
    drive3_idle();
    for (int j = 0; j < OUT_NUM; j++) begin
      exp_q[j].delete();
      m_ptr[j] = 0;
    end
    m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < OUT_NUM; j++) begin
      check("rst_resp_vld", 32'(bus.resp_vld[j]), 32'd0);
      check("rst_resp_txnid", 32'(bus.resp_txnid[j]), 32'd0);
      check("rst_resp_sideband", 32'(bus.resp_sideband[j]), 32'd0);
    end
    check("rst_err_dst", 32'(err_dst), 32'd0);
    check("rst_err_dst3", 32'(err_dst3), 32'd0);
    check("rst_bank_rdy", 32'(bus.bank_resp_rdy), 32'd0);
  endtask

  task automatic set_bank(input int i, input int dst, input logic [TXNID_W-1:0] txn);
    b_vld[i] = 1'b1;
    b_dst[i] = dst;
    b_txn[i] = txn;
    b_sb[i]  = SB_W'($urandom);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #1;
    do_reset();

    // Single completion: bank2 -> port1.
    set_bank(2, 1, 8'h15);
    cycle();
    check("single_rdy", 32'(last_rdy), 32'h4);
    check("single_vld1", 32'(bus.resp_vld), 32'h2);
    check("single_txnid", 32'(bus.resp_txnid[1]), 32'h15);
    cycle();
    check("single_vld2", 32'(bus.resp_vld), 32'h0);

    // Round-robin fairness on port 0 with all banks always requesting.
    do_reset();
    for (int i = 0; i < NB; i++) set_bank(i, 0, 8'hA0 + 8'(i));
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_rdy", 32'(last_rdy), 32'(1) << (k % 4));
      check("rr_txnid", 32'(bus.resp_txnid[0]), 32'hA0 + 32'(k % 4));
      for (int i = 0; i < NB; i++) b_vld[i] = 1'b1;
    end
    for (int i = 0; i < NB; i++) b_vld[i] = 1'b0;
    cycle();

    // Parallel outputs: banks 0..3 -> ports 3..0.
    do_reset();
    for (int i = 0; i < NB; i++) set_bank(i, 3 - i, 8'h50 + 8'(i));
    cycle();
    check("par_rdy", 32'(last_rdy), 32'hF);
    check("par_vld", 32'(bus.resp_vld), 32'hF);
    for (int j = 0; j < OUT_NUM; j++)
      check("par_txnid", 32'(bus.resp_txnid[j]), 32'h50 + 32'(3 - j));
    cycle();

    // Backpressure: port 0 stalls while bank1 holds its second completion.
    do_reset();
    set_bank(1, 0, 8'h31);
    cycle();
    set_bank(1, 0, 8'h32);
    r_rdy[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_rdy_low", 32'(last_rdy[1]), 32'd0);
      check("bp_hold_txnid", 32'(bus.resp_txnid[0]), 32'h31);
      check("bp_hold_vld", 32'(bus.resp_vld[0]), 32'd1);
    end
    r_rdy[0] = 1'b1;
    cycle();
    check("bp_rdy_high", 32'(last_rdy[1]), 32'd1);
    check("bp_next_vld", 32'(bus.resp_vld[0]), 32'd1);
    check("bp_next_txnid", 32'(bus.resp_txnid[0]), 32'h32);
    cycle();

    // Illegal destination on the 4-port instance.
    do_reset();
    set_bank(0, 5, 8'h66);
    cycle();
    check("ill_rdy", 32'(last_rdy), 32'h1);
    check("ill_vld", 32'(bus.resp_vld), 32'h0);
    check("ill_err", 32'(err_dst), 32'd1);
    repeat (3) cycle();
    check("ill_err_sticky", 32'(err_dst), 32'd1);

    // Illegal destination on the 3-port instance: dst=3 is out of range.
    do_reset();
    bus3.bank_resp_vld    = 4'b0001;
    bus3.bank_resp_dst[0] = 3'd3;
    bus3.bank_resp_txnid[0] = 8'h33;
    #1;
    check("ill3_rdy", 32'(bus3.bank_resp_rdy), 32'h1);
    @(posedge clk); @(negedge clk);
    bus3.bank_resp_vld = '0;
    check("ill3_vld", 32'(bus3.resp_vld), 32'h0);
    check("ill3_err", 32'(err_dst3), 32'd1);
    bus3.bank_resp_vld      = 4'b0010;
    bus3.bank_resp_dst[1]   = 3'd2;
    bus3.bank_resp_txnid[1] = 8'h42;
    #1;
    check("ok3_rdy", 32'(bus3.bank_resp_rdy), 32'h2);
    @(posedge clk); @(negedge clk);
    bus3.bank_resp_vld = '0;
    check("ok3_vld", 32'(bus3.resp_vld), 32'h4);
    check("ok3_txnid", 32'(bus3.resp_txnid[2]), 32'h42);
    repeat (3) @(negedge clk);
    check("ill3_err_sticky", 32'(err_dst3), 32'd1);

    // Mid-operation asynchronous reset with a held completion and err set.
    do_reset();
    set_bank(2, 0, 8'h60);
    set_bank(1, 1, 8'h77);
    set_bank(3, 6, 8'h99);
    r_rdy[1] = 1'b0;
    cycle();
    check("mid_vld_before", 32'(bus.resp_vld[1]), 32'd1);
    check("mid_err_before", 32'(err_dst), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_vld_async", 32'(bus.resp_vld), 32'h0);
    check("mid_err_async", 32'(err_dst), 32'd0);
    do_reset();
    for (int i = 0; i < NB; i++) set_bank(i, 0, 8'hC0 + 8'(i));
    cycle();
    check("mid_first_grant", 32'(last_rdy), 32'h1);
    for (int i = 0; i < NB; i++) b_vld[i] = 1'b0;
    cycle();

    // Randomized traffic, legal destinations first, then with illegal ones.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (!b_vld[i] && $urandom_range(0, 99) < 60) begin
          if (c >= 1500 && $urandom_range(0, 19) == 0)
            set_bank(i, int'($urandom_range(4, 7)), TXNID_W'($urandom));
          else
            set_bank(i, int'($urandom_range(0, OUT_NUM - 1)), TXNID_W'($urandom));
        end
      end
      for (int j = 0; j < OUT_NUM; j++) r_rdy[j] = ($urandom_range(0, 99) < 70);
      cycle();
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
